// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and elaboration-time helpers.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/csel_slice.sv
// One carry-select slice: two ripple chains (carry-in 0 and 1) followed by a late 2:1 select.
module csel_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0]   c0, c1;
  logic [SLICE_W-1:0] s0, s1;

  always_comb begin
    c0 = '0;
    c1 = '0;
    s0 = '0;
    s1 = '0;
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int i = 0; i < SLICE_W; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign sum  = cin ? s1 : s0;
  assign cout = cin ? c1[SLICE_W] : c0[SLICE_W];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor; each stage resolves a group of slices and
// forwards the resolved low sum, the carry and the still-unresolved upper operand bits.
module pipelined_csel_adder
  import alu_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int SLICE_W          = 8,
  parameter int SLICES_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int SPS        = (SLICES_PER_STAGE < 1) ? 1 : SLICES_PER_STAGE;
  localparam int LATENCY    = ceil_div(NUM_SLICES, SPS);

  if ((WIDTH % SLICE_W) != 0 || SLICES_PER_STAGE < 1) begin : g_bad_params
    $error("pipelined_csel_adder: WIDTH must be a multiple of SLICE_W and SLICES_PER_STAGE >= 1");
  end

  // Handshake: a beat is accepted when in_valid && in_ready and leaves when
  // out_valid && out_ready. The whole pipe advances together (adv); when adv is
  // low every stage holds data and valid, so out_* stay stable under backpressure.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    localparam int FIRST = k * SPS;
    localparam int NS    = ((NUM_SLICES - FIRST) < SPS) ? (NUM_SLICES - FIRST) : SPS;
    localparam int LO    = FIRST * SLICE_W;
    localparam int HI    = LO + NS * SLICE_W;
    localparam bit LAST  = (k == LATENCY - 1);

    logic [WIDTH-1:LO]       st_a, st_b;
    logic [HI-1:LO]          st_b_eff;
    logic                    st_cin, st_sub, st_valid;
    logic [NS*SLICE_W-1:0]   slice_sum;
    logic [HI-1:0]           sum_d, sum_q;
    logic                    carry_d, carry_q, valid_d, valid_q;

    if (k == 0) begin : g_first
      assign st_a     = in_a;
      assign st_b     = in_b;
      assign st_sub   = in_sub;
      assign st_valid = in_valid;
      assign st_cin   = (in_sub == OP_ADD) ? in_cin : 1'b1;
      always_comb sum_d = slice_sum;
    end else begin : g_chain
      assign st_a     = g_stage[k-1].g_mid.a_q;
      assign st_b     = g_stage[k-1].g_mid.b_q;
      assign st_sub   = g_stage[k-1].g_mid.sub_q;
      assign st_valid = g_stage[k-1].valid_q;
      assign st_cin   = g_stage[k-1].carry_q;
      always_comb sum_d = {slice_sum, g_stage[k-1].sum_q};
    end

    // Operand B travels unmodified with the mode bit; each stage inverts only its own slices.
    assign st_b_eff = (st_sub == OP_SUB) ? ~st_b[HI-1:LO] : st_b[HI-1:LO];

    for (genvar j = 0; j < NS; j++) begin : g_slice
      logic cin_j, cout_j;
      if (j == 0) begin : g_cin0
        assign cin_j = st_cin;
      end else begin : g_cinn
        assign cin_j = g_slice[j-1].cout_j;
      end
      csel_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a   (st_a[LO + j*SLICE_W +: SLICE_W]),
        .b   (st_b_eff[LO + j*SLICE_W +: SLICE_W]),
        .cin (cin_j),
        .sum (slice_sum[j*SLICE_W +: SLICE_W]),
        .cout(cout_j)
      );
    end

    always_comb begin
      carry_d = g_slice[NS-1].cout_j;
      valid_d = st_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else if (adv) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end
    end

    if (!LAST) begin : g_mid
      logic [WIDTH-1:HI] a_d, a_q, b_d, b_q;
      logic              sub_d, sub_q;

      always_comb begin
        a_d   = st_a[WIDTH-1:HI];
        b_d   = st_b[WIDTH-1:HI];
        sub_d = st_sub;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
        end else if (adv) begin
          a_q   <= a_d;
          b_q   <= b_d;
          sub_q <= sub_d;
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q, zero_d, zero_q;

      always_comb begin
        ovf_d  = (st_a[WIDTH-1] == st_b_eff[WIDTH-1]) && (sum_d[WIDTH-1] != st_a[WIDTH-1]);
        zero_d = ~|sum_d;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = g_stage[LATENCY-1].valid_q;
  assign out_sum   = g_stage[LATENCY-1].sum_q;
  assign out_cout  = g_stage[LATENCY-1].carry_q;
  assign out_ovf   = g_stage[LATENCY-1].g_last.ovf_q;
  assign out_zero  = g_stage[LATENCY-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: directed vector table, reset corner, randomized
// backpressure stream on the default build and a full-rate stream on a 16/4/1 build.
module tb_pipelined_csel_adder;

  localparam int LAT32  = 2;
  localparam int LAT16  = 4;
  localparam int N_RAND = 1000;
  localparam int N16    = 200;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [31:0] out_sum;

  logic        in16_valid, in16_ready, in16_cin, in16_sub;
  logic [15:0] in16_a, in16_b;
  logic        out16_valid, out16_ready, out16_cout, out16_ovf, out16_zero;
  logic [15:0] out16_sum;

  int n_tests = 0;
  int n_fail  = 0;

  pipelined_csel_adder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  pipelined_csel_adder #(.WIDTH(16), .SLICE_W(4), .SLICES_PER_STAGE(1)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in16_valid), .in_ready(in16_ready), .in_a(in16_a), .in_b(in16_b),
    .in_cin(in16_cin), .in_sub(in16_sub),
    .out_valid(out16_valid), .out_ready(out16_ready), .out_sum(out16_sum),
    .out_cout(out16_cout), .out_ovf(out16_ovf), .out_zero(out16_zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow, unsigned compare for carry/borrow.
  function automatic logic [34:0] ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
    longint md, ua, ub, sa, sb, tot, res;
    logic   co, ov;
    md  = longint'(1) << w;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = (ua >= md / 2) ? ua - md : ua;
    sb  = (ub >= md / 2) ? ub - md : ub;
    if (sub) begin
      tot = ua - ub;
      co  = (ua >= ub);
      res = sa - sb;
    end else begin
      tot = ua + ub + longint'(cin);
      co  = (tot >= md);
      res = sa + sb + longint'(cin);
    end
    tot = ((tot % md) + md) % md;
    ov  = (res >= md / 2) || (res < -(md / 2));
    return {32'(tot), co, ov, (tot == 0)};
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboards ----------------
  logic [34:0] exp_q[$];
  logic [34:0] exp16_q[$];
  logic [34:0] exp_w;
  bit          mon_en = 0;
  bit          held = 0;
  logic [35:0] held_val;
  int          cyc = 0;
  int          first_acc16 = -1;
  int          last_xfer16 = -1;
  int          n_acc16 = 0;
  int          n_out16 = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst || !mon_en) begin
      held = 0;
    end else begin
      if (held)
        check("stall_hold", {out_valid, out_sum, out_cout, out_ovf, out_zero}, held_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("sb_result", {out_sum, out_cout, out_ovf, out_zero}, exp_w);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_model(32, in_a, in_b, in_cin, in_sub));
      held     = out_valid && !out_ready;
      held_val = {1'b1, out_sum, out_cout, out_ovf, out_zero};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out16_valid && out16_ready) begin
        n_out16++;
        last_xfer16 = cyc;
        if (exp16_q.size() == 0)
          check("sb16_unexpected_beat", 1, 0);
        else
          check("sb16_result", {16'h0, out16_sum, out16_cout, out16_ovf, out16_zero}, exp16_q.pop_front());
      end
      if (in16_valid && in16_ready) begin
        n_acc16++;
        if (first_acc16 < 0) first_acc16 = cyc;
        exp16_q.push_back(ref_model(16, {16'h0, in16_a}, {16'h0, in16_b}, in16_cin, in16_sub));
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] sum;
    logic        cout, ovf, zero;
  } vec_t;

  vec_t vecs[9];

  task automatic apply_vec(input vec_t v, input int idx);
    int n;
    bit seen;
    @(posedge clk); #1;
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub; in_valid = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 12) begin
      @(posedge clk);
      n++;
      if (n == 1) begin #1 in_valid = 1'b0; end
      @(negedge clk);
      seen = out_valid;
    end
    check($sformatf("vec%0d_latency", idx), seen ? n : 0, LAT32);
    check($sformatf("vec%0d_sum", idx), out_sum, v.sum);
    check($sformatf("vec%0d_flags", idx), {out_cout, out_ovf, out_zero}, {v.cout, v.ovf, v.zero});
  endtask

  // ---------------- stimulus ----------------
  bit acc;
  int sent;
  int waited;
  bit flag;

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; in_sub = 0; out_ready = 1'b1;
    in16_valid = 0; in16_a = 0; in16_b = 0; in16_cin = 0; in16_sub = 0; out16_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_fields", {out_sum, out_cout, out_ovf, out_zero}, 0);
    check("reset16_out_valid", out16_valid, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

    // Reset with two beats in flight and the output stalled.
    @(posedge clk); #1;
    in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_cin = 0; in_sub = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 32'h0000_0005; in_b = 32'h0000_0003; in_sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_in_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_flags", {out_cout, out_ovf, out_zero}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    flag = 0;
    repeat (LAT32 + 4) begin
      @(negedge clk);
      if (out_valid) flag = 1;
    end
    check("rst_no_replay", flag, 0);

    // Random stream with random valid and backpressure.
    mon_en = 1;
    acc = 0;
    sent = 0;
    while (sent < N_RAND) begin
      @(posedge clk); #1;
      if (!(in_valid && !acc)) begin
        if ($urandom_range(0, 1) == 1) begin
          in_a = rand_word(); in_b = rand_word();
          in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("rand_drain_left", exp_q.size(), 0);
    mon_en = 0;

    // Full-rate stream into the 16/4/1 build.
    for (int i = 0; i < N16; i++) begin
      @(posedge clk); #1;
      in16_a = 16'($urandom_range(0, 16'hFFFF));
      in16_b = (i % 5 == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFF));
      in16_cin = 1'($urandom_range(0, 1));
      in16_sub = 1'($urandom_range(0, 1));
      in16_valid = 1'b1;
    end
    @(posedge clk); #1;
    in16_valid = 1'b0;
    waited = 0;
    while (exp16_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("w16_drain_left", exp16_q.size(), 0);
    check("w16_accepted", n_acc16, N16);
    check("w16_emitted", n_out16, N16);
    check("w16_span_cycles", last_xfer16 - first_acc16, N16 - 1 + LAT16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
